// File: rtl/ex_mul_unit_pkg.sv
// Shared definitions for the EX-stage iterative multiplier and the decode-side
// hazard logic that stalls for its fixed latency.
package ex_mul_unit_pkg;

    localparam int DEFAULT_XLEN       = 32;
    // The hazard unit stalls for this many cycles; the multiplier latency uses the same value.
    localparam int DEFAULT_MUL_STALLS = 4;

    localparam logic [1:0] MUL_OP_MUL    = 2'b00;
    localparam logic [1:0] MUL_OP_MULH   = 2'b01;
    localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
    localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

    localparam logic [1:0] MUL_IDLE = 2'd0;
    localparam logic [1:0] MUL_RUN  = 2'd1;
    localparam logic [1:0] MUL_DONE = 2'd2;

    function automatic logic op_a_signed(input logic [1:0] op);
        return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
    endfunction

    function automatic logic op_b_signed(input logic [1:0] op);
        return op == MUL_OP_MULH;
    endfunction

endpackage

// File: rtl/ex_mul_unit_if.sv
// Request/response bundle between the EX stage and the iterative multiplier.
interface ex_mul_unit_if #(
    parameter int XLEN = 32
);
    logic            EX_mul;
    logic [1:0]      mul_op;
    logic [XLEN-1:0] EX_ra_val;
    logic [XLEN-1:0] EX_rb_val;
    logic            flush;
    logic            mul_busy;
    logic            mul_done;
    logic [XLEN-1:0] mul_result;

    modport master (
        output EX_mul, mul_op, EX_ra_val, EX_rb_val, flush,
        input  mul_busy, mul_done, mul_result
    );

    modport slave (
        input  EX_mul, mul_op, EX_ra_val, EX_rb_val, flush,
        output mul_busy, mul_done, mul_result
    );
endinterface

// File: rtl/ex_mul_unit_mul_step.sv
// One radix-2^CHUNK step: XLEN x CHUNK partial product, shifted into place
// and added to the 2*XLEN unsigned accumulator.
module mul_step #(
    parameter int XLEN  = 32,
    parameter int CHUNK = 8,
    parameter int CW    = 2
) (
    input  logic [XLEN-1:0]   mcand,
    input  logic [CHUNK-1:0]  mplier_chunk,
    input  logic [CW-1:0]     step,
    input  logic [2*XLEN-1:0] acc_in,
    output logic [2*XLEN-1:0] acc_out
);
    logic [2*XLEN-1:0] pp;
    logic [31:0]       shamt;

    always_comb begin
        pp      = {{XLEN{1'b0}}, mcand} * {{(2*XLEN-CHUNK){1'b0}}, mplier_chunk};
        shamt   = 32'(step) * 32'(CHUNK);
        acc_out = acc_in + (pp << shamt);
    end
endmodule

// File: rtl/ex_mul_unit.sv
// Fixed-latency iterative multiplier (MUL/MULH/MULHSU/MULHU) executing in EX.
// Works on magnitudes and applies the product sign once at the end.
module ex_mul_unit
    import ex_mul_unit_pkg::*;
#(
    parameter int XLEN       = DEFAULT_XLEN,
    parameter int MUL_STALLS = DEFAULT_MUL_STALLS
) (
    input  logic          clk,
    input  logic          rst,
    ex_mul_unit_if.slave  bus
);
    localparam int CHUNK = XLEN / MUL_STALLS;
    localparam int CW    = (MUL_STALLS > 1) ? $clog2(MUL_STALLS) : 1;

    logic [1:0]        state;
    logic [CW-1:0]     step_cnt;
    logic [2*XLEN-1:0] acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic              neg;
    logic [1:0]        op;

    logic              sign_a, sign_b, last_step;
    logic [XLEN-1:0]   mag_a, mag_b;
    logic [XLEN-1:0]   step_mcand;
    logic [CHUNK-1:0]  step_chunk;
    logic [CW-1:0]     step_idx;
    logic [2*XLEN-1:0] step_acc, step_out, prod;

    // The start cycle feeds the step unit straight from the operand ports,
    // so step 0 retires on the same edge that leaves IDLE.
    always_comb begin
        sign_a     = op_a_signed(bus.mul_op) && bus.EX_ra_val[XLEN-1];
        sign_b     = op_b_signed(bus.mul_op) && bus.EX_rb_val[XLEN-1];
        mag_a      = sign_a ? -bus.EX_ra_val : bus.EX_ra_val;
        mag_b      = sign_b ? -bus.EX_rb_val : bus.EX_rb_val;
        last_step  = step_cnt == CW'(MUL_STALLS - 1);
        step_mcand = (state == MUL_IDLE) ? mag_a : mcand;
        step_chunk = (state == MUL_IDLE) ? mag_b[CHUNK-1:0] : mplier[CHUNK-1:0];
        step_idx   = (state == MUL_IDLE) ? '0 : step_cnt;
        step_acc   = (state == MUL_IDLE) ? '0 : acc;
    end

    mul_step #(
        .XLEN  (XLEN),
        .CHUNK (CHUNK),
        .CW    (CW)
    ) u_mul_step (
        .mcand        (step_mcand),
        .mplier_chunk (step_chunk),
        .step         (step_idx),
        .acc_in       (step_acc),
        .acc_out      (step_out)
    );

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would chain updates within one edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= MUL_IDLE;
            step_cnt <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            neg      <= 1'b0;
            op       <= MUL_OP_MUL;
        end else if (bus.flush) begin
            state    <= MUL_IDLE;
            step_cnt <= '0;
        end else begin
            case (state)
                MUL_IDLE: if (bus.EX_mul) begin
                    mcand    <= mag_a;
                    mplier   <= mag_b >> CHUNK;
                    acc      <= step_out;
                    neg      <= sign_a ^ sign_b;
                    op       <= bus.mul_op;
                    step_cnt <= CW'(1);
                    state    <= (MUL_STALLS == 1) ? MUL_DONE : MUL_RUN;
                end
                MUL_RUN: begin
                    acc    <= step_out;
                    mplier <= mplier >> CHUNK;
                    if (last_step) begin
                        state    <= MUL_DONE;
                        step_cnt <= '0;
                    end else begin
                        step_cnt <= step_cnt + 1'b1;
                    end
                end
                MUL_DONE: state <= MUL_IDLE;
                default:  state <= MUL_IDLE;
            endcase
        end
    end

    // NOTE: each output gets a default before the conditional override so no latch is inferred.
    always_comb begin
        prod           = neg ? -acc : acc;
        bus.mul_busy   = state != MUL_IDLE;
        bus.mul_done   = state == MUL_DONE;
        bus.mul_result = '0;
        if (state == MUL_DONE)
            bus.mul_result = (op == MUL_OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
    end
endmodule

// File: tb/tb_ex_mul_unit.sv
// Scoreboard bench for ex_mul_unit: the driver queues expected results and done
// cycles; a negedge monitor pops and compares whenever mul_done is seen.
module tb_ex_mul_unit;
    import ex_mul_unit_pkg::*;

    localparam int XLEN   = 32;
    localparam int STALLS = 4;

    typedef struct {
        logic [XLEN-1:0] res;
        int unsigned     cyc;
    } exp_t;

    logic        clk;
    logic        rst;
    int unsigned cycle = 0;
    int          checks = 0;
    int          errors = 0;
    exp_t        exp_q[$];

    ex_mul_unit_if #(.XLEN(XLEN)) bus();

    ex_mul_unit #(
        .XLEN       (XLEN),
        .MUL_STALLS (STALLS)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cycle <= cycle + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: time %0t reached, required finish earlier", $time);
        $fatal(1, "watchdog");
    end

    // Reference: full-width product of the operands extended per their signedness.
    function automatic logic [XLEN-1:0] ref_mul(input logic [1:0] op, input logic [XLEN-1:0] a,
                                               input logic [XLEN-1:0] b);
        logic signed [65:0] ea, eb, p;
        ea = (op == MUL_OP_MULH || op == MUL_OP_MULHSU) ? {{34{a[XLEN-1]}}, a} : {34'd0, a};
        eb = (op == MUL_OP_MULH) ? {{34{b[XLEN-1]}}, b} : {34'd0, b};
        p  = ea * eb;
        return (op == MUL_OP_MUL) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [XLEN-1:0] pick();
        case ($urandom_range(0, 6))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: cycle %0d got %h expected %h", name, cycle, got, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            if (bus.mul_done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: cycle %0d result %h, expected no done", cycle,
                             bus.mul_result);
                end else begin
                    e = exp_q.pop_front();
                    check("done_cycle", 64'(cycle), 64'(e.cyc));
                    check("result", 64'(bus.mul_result), 64'(e.res));
                end
            end else begin
                check("idle_result", 64'(bus.mul_result), 64'd0);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input bit expect_done);
        exp_t e;
        bus.EX_mul    = 1'b1;
        bus.mul_op    = op;
        bus.EX_ra_val = a;
        bus.EX_rb_val = b;
        if (expect_done) begin
            e.res = ref_mul(op, a, b);
            e.cyc = cycle + STALLS;
            exp_q.push_back(e);
        end
        tick();
        bus.EX_mul = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b);
        issue(op, a, b, 1'b1);
        repeat (STALLS) tick();
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || bus.mul_busy) && n < 60) begin
            tick();
            n++;
        end
        if (n >= 60) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
        end
    endtask

    initial begin
        bus.EX_mul    = 1'b0;
        bus.mul_op    = MUL_OP_MUL;
        bus.EX_ra_val = '0;
        bus.EX_rb_val = '0;
        bus.flush     = 1'b0;
        rst           = 1'b0;
        tick();
        tick();
        check("rst_busy", 64'(bus.mul_busy), 64'd0);
        check("rst_done", 64'(bus.mul_done), 64'd0);
        check("rst_result", 64'(bus.mul_result), 64'd0);
        rst = 1'b1;
        tick();

        // 7 x 6: busy in cycles 1..4, done only in cycle 4
        issue(MUL_OP_MUL, 32'd7, 32'd6, 1'b1);
        for (int i = 1; i <= 5; i++) begin
            check($sformatf("busy_c%0d", i), 64'(bus.mul_busy), 64'(i <= STALLS));
            check($sformatf("done_c%0d", i), 64'(bus.mul_done), 64'(i == STALLS));
            tick();
        end
        wait_drain();

        // Sign-handling corners, issued back to back
        run_op(MUL_OP_MUL,    32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MUL_OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MUL_OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op(MUL_OP_MULHSU, 32'hFFFF_FFFF, 32'd2);
        run_op(MUL_OP_MULH,   32'h8000_0000, 32'h8000_0000);
        wait_drain();

        // EX_mul held high while busy must not restart or relatch
        issue(MUL_OP_MUL, 32'd3, 32'd5, 1'b1);
        for (int i = 0; i < STALLS; i++) begin
            bus.EX_mul    = 1'b1;
            bus.mul_op    = 2'($urandom_range(0, 3));
            bus.EX_ra_val = $urandom;
            bus.EX_rb_val = $urandom;
            tick();
        end
        run_op(MUL_OP_MUL, 32'd9, 32'd9);
        wait_drain();

        // Flush in cycle 2 kills the op; restart immediately in cycle 3
        issue(MUL_OP_MUL, 32'd100, 32'd100, 1'b0);
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        check("flush_idle", 64'(bus.mul_busy), 64'd0);
        issue(MUL_OP_MUL, 32'd2, 32'd2, 1'b1);
        wait_drain();

        // Flush wins over a start in IDLE
        bus.EX_mul    = 1'b1;
        bus.flush     = 1'b1;
        bus.EX_ra_val = 32'd5;
        bus.EX_rb_val = 32'd5;
        tick();
        bus.EX_mul = 1'b0;
        bus.flush  = 1'b0;
        check("flush_start_busy", 64'(bus.mul_busy), 64'd0);
        repeat (STALLS + 1) tick();

        // Asynchronous reset in the middle of cycle 2
        issue(MUL_OP_MUL, 32'd123, 32'd45, 1'b0);
        tick();
        #3;
        rst = 1'b0;
        #1;
        check("arst_busy", 64'(bus.mul_busy), 64'd0);
        check("arst_done", 64'(bus.mul_done), 64'd0);
        check("arst_result", 64'(bus.mul_result), 64'd0);
        tick();
        rst = 1'b1;
        tick();
        check("post_rst_busy", 64'(bus.mul_busy), 64'd0);
        run_op(MUL_OP_MUL, 32'd1, 32'd1);
        wait_drain();

        // Random ops with random idle gaps
        for (int i = 0; i < 60; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick());
            repeat ($urandom_range(0, 2)) tick();
        end
        wait_drain();
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ex_mul_unit.md
# ex_mul_unit

Iterative multiplier in the EX stage. It executes MUL, MULH, MULHSU and MULHU over a fixed number of cycles. It is the executing end of the multiply stall protocol: decode-side hazard logic sees `EX_mul`, stalls F/D for exactly `MUL_STALLS` cycles, and relies on this block to present the product in the last of those cycles. Latency is fixed and data-independent, so no back-pressure signal exists.

## Interface
Parameters:
- `XLEN`, default 32: operand and result width.
- `MUL_STALLS`, default 4: number of cycles after the start cycle. It must divide `XLEN`. `CHUNK = XLEN/MUL_STALLS` multiplier bits are retired per cycle.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: reset, asynchronous, active-low.
- `EX_mul`, in, 1: a multiply instruction is in EX.
- `mul_op`, in, 2: operation select. 00 = MUL (low word), 01 = MULH (signed×signed, high word), 10 = MULHSU (signed×unsigned, high word), 11 = MULHU (unsigned×unsigned, high word).
- `EX_ra_val`, in, XLEN: operand a (rs1 after forwarding).
- `EX_rb_val`, in, XLEN: operand b (rs2 after forwarding).
- `flush`, in, 1: EX kill. Aborts any operation in flight.
- `mul_busy`, out, 1: an operation occupies the unit.
- `mul_done`, out, 1: `mul_result` is valid this cycle.
- `mul_result`, out, XLEN: selected word of the product.

## Operation
- States are IDLE, RUN and DONE.
  - IDLE → RUN on `EX_mul && !flush`. This is the start cycle, called cycle 0.
  - RUN stays in RUN until `step_cnt == MUL_STALLS-1`, then goes to DONE.
  - DONE → IDLE unconditionally.
  - Any state → IDLE on `flush`. `flush` has priority over start.
- Start cycle: compute the magnitudes combinationally.
  - `|a|` is formed if `a` is signed for this op (MULH, MULHSU) and `a[XLEN-1]` is set.
  - `|b|` is formed only for MULH.
  - `neg = sign_a ^ sign_b` and the op are latched.
  - The magnitude of 0x80000000 is taken as unsigned 2^31, which is correct without special-casing.
- Step k (k = 0..MUL_STALLS-1) happens at edge k+1.
  - `acc += (mcand × mplier[CHUNK-1:0]) << (k·CHUNK)`, with `acc` being 2·XLEN bits unsigned.
  - `mplier` shifts right by CHUNK.
  - Step 0 at edge 1 uses the start-cycle magnitudes directly, so no separate latch cycle is needed. `acc` starts from 0.
- Final result: `prod = neg ? -acc : acc` (2·XLEN wide, combinational from registers).
  - `mul_result` = `prod[XLEN-1:0]` for MUL, otherwise `prod[2·XLEN-1:XLEN]`.
- `mul_result` is driven only while `mul_done`. Otherwise it is 0.
- `EX_mul` asserted while not IDLE is ignored: operands are not relatched and the count is not restarted.

## Timing
- Reset (asserted low, async): state = IDLE, `step_cnt`, `acc`, latched operands, `neg` and op are all 0. `mul_busy = 0`, `mul_done = 0`, `mul_result = 0`.
- Start in cycle 0 → `mul_busy` is high in cycles 1..MUL_STALLS, matching the hazard unit's stall window exactly.
- `mul_done` is high in cycle MUL_STALLS only (state DONE), for exactly one cycle. EX/MEM captures `mul_result` at the end of that cycle.
- Back-to-back: DONE returns to IDLE at edge MUL_STALLS+1, so a new start is accepted in cycle MUL_STALLS+1 with no bubble.
- `flush` in any cycle → IDLE at the next edge. `mul_done` is never raised for a flushed op. `flush` together with `EX_mul` in IDLE → no start.
- Reset deasserted mid-operation → the unit resumes in IDLE. No partial result is ever presented.
- With MUL_STALLS = 1, RUN is skipped: IDLE → DONE at edge 1.

## Structure
- Shared package:
  - op encodings `MUL_OP_MUL`, `MUL_OP_MULH`, `MUL_OP_MULHSU`, `MUL_OP_MULHU`;
  - state encoding `MUL_IDLE`, `MUL_RUN`, `MUL_DONE`;
  - default `MUL_STALLS`, which the hazard unit also uses, so the stall window and the latency cannot diverge.
- One sub-module, `mul_step`: a combinational XLEN × CHUNK partial-product generator plus shifted 2·XLEN accumulate. Everything else (FSM, counter, sign handling) stays in `ex_mul_unit`.

## Test plan
- MUL, a = 7, b = 6, start in cycle 0 → `mul_busy` high in cycles 1–4, `mul_done` only in cycle 4, `mul_result` = 42.
- MUL then MULH with a = b = 0xFFFFFFFF → MUL = 0x00000001, MULH = 0x00000000.
- MULHU with 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MULHSU with a = 0xFFFFFFFF, b = 2 → 0xFFFFFFFF. MULH with 0x80000000 × 0x80000000 → 0x40000000.
- Back-to-back: MUL 3×5 starting cycle 0 and MUL 9×9 starting cycle 5 → done in cycle 4 with 15 and in cycle 9 with 81. `EX_mul` held high during cycles 1–4 causes no restart.
- `flush` in cycle 2 of 100×100 → IDLE in cycle 3, no `mul_done`. An immediate restart of 2×2 in cycle 3 → done in cycle 7 with 4.
- `rst` pulsed low asynchronously mid-cycle 2 → all outputs 0 immediately. After release, MUL 1×1 completes normally with result 1.
